// File: rtl/bcd_updown_cnt.sv
// N-digit BCD up/down counter with synchronous load and programmable top.
// Carry, borrow and load-reject flags are one-cycle registered pulses.
module bcd_updown_cnt #(
  parameter int                  DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] TOP      = {DIGITS{4'h9}},
  parameter bit                  SATURATE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DIN,
  output logic [4*DIGITS-1:0]   DOUT,
  output logic                  COUT,
  output logic                  BOUT,
  output logic                  TC,
  output logic                  ERR
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] inc;
  logic [W-1:0] dec;
  logic         din_bcd;
  logic         din_ok;
  logic         at_top;
  logic         at_zero;

  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] ni;
    logic [3:0] nd;
    inc     = DOUT;
    dec     = DOUT;
    din_bcd = 1'b1;
    c       = 1'b1;
    b       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ni = DOUT[4*i +: 4];
      nd = DOUT[4*i +: 4];
      if (c) begin
        if (ni == 4'd9) begin
          inc[4*i +: 4] = 4'd0;
        end else begin
          inc[4*i +: 4] = ni + 4'd1;
          c = 1'b0;
        end
      end
      if (b) begin
        if (nd == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = nd - 4'd1;
          b = 1'b0;
        end
      end
      if (DIN[4*i +: 4] > 4'd9) din_bcd = 1'b0;
    end
  end

  // With every nibble valid, BCD ordering matches binary ordering.
  assign din_ok  = din_bcd && (DIN <= TOP);
  assign at_top  = (DOUT == TOP);
  assign at_zero = (DOUT == '0);
  assign TC      = UP ? at_top : at_zero;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DOUT <= '0;
      COUT <= 1'b0;
      BOUT <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      COUT <= 1'b0;
      BOUT <= 1'b0;
      ERR  <= 1'b0;
      if (LOAD) begin
        if (din_ok) DOUT <= DIN;
        else        ERR  <= 1'b1;
      end else if (EN && UP) begin
        if (!at_top) begin
          DOUT <= inc;
        end else if (!SATURATE) begin
          DOUT <= '0;
          COUT <= 1'b1;
        end
      end else if (EN) begin
        if (!at_zero) begin
          DOUT <= dec;
        end else if (!SATURATE) begin
          DOUT <= TOP;
          BOUT <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Directed bench for bcd_updown_cnt: mod-60 wrapping and saturating copies.
// Both instances share stimulus; expectations are hand-computed.
module tb_bcd_updown_cnt;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       UP = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] DIN = 8'h00;

  logic [7:0] w_dout;
  logic       w_cout, w_bout, w_tc, w_err;
  logic [7:0] s_dout;
  logic       s_cout, s_bout, s_tc, s_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  bcd_updown_cnt #(.DIGITS(2), .TOP(8'h59), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
    .DOUT(w_dout), .COUT(w_cout), .BOUT(w_bout), .TC(w_tc), .ERR(w_err)
  );

  bcd_updown_cnt #(.DIGITS(2), .TOP(8'h59), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .DIN(DIN),
    .DOUT(s_dout), .COUT(s_cout), .BOUT(s_bout), .TC(s_tc), .ERR(s_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic flags(input string tag, input logic c, input logic b,
                       input logic e);
    chk({tag, " cout"}, {7'd0, w_cout}, {7'd0, c});
    chk({tag, " bout"}, {7'd0, w_bout}, {7'd0, b});
    chk({tag, " err"},  {7'd0, w_err},  {7'd0, e});
  endtask

  initial begin
    logic [7:0] exp_v;

    // T1: reset state, then async reset from a loaded value
    #12;
    chk("rst dout", w_dout, 8'h00);
    flags("rst", 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    LOAD = 1'b1; DIN = 8'h37;
    step();
    LOAD = 1'b0;
    chk("ld37", w_dout, 8'h37);
    RST = 1'b0;
    #2;
    chk("async rst dout", w_dout, 8'h00);
    flags("async rst", 1'b0, 1'b0, 1'b0);
    RST = 1'b1;

    // T2: up wrap
    LOAD = 1'b1; DIN = 8'h57;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    chk("ld57", w_dout, 8'h57);
    step();
    chk("up58", w_dout, 8'h58);
    flags("up58", 1'b0, 1'b0, 1'b0);
    step();
    chk("up59", w_dout, 8'h59);
    chk("up59 tc", {7'd0, w_tc}, 8'h01);
    chk("up59 cout", {7'd0, w_cout}, 8'h00);
    step();
    chk("up00", w_dout, 8'h00);
    chk("up00 cout", {7'd0, w_cout}, 8'h01);
    chk("up00 tc", {7'd0, w_tc}, 8'h00);
    EN = 1'b0;
    step();
    chk("cout drop", {7'd0, w_cout}, 8'h00);

    // T3: down wrap
    LOAD = 1'b1; DIN = 8'h01;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
    step();
    chk("dn00", w_dout, 8'h00);
    chk("dn00 tc", {7'd0, w_tc}, 8'h01);
    chk("dn00 bout", {7'd0, w_bout}, 8'h00);
    step();
    chk("dn59", w_dout, 8'h59);
    chk("dn59 bout", {7'd0, w_bout}, 8'h01);
    chk("dn59 tc", {7'd0, w_tc}, 8'h00);
    step();
    chk("dn58", w_dout, 8'h58);
    chk("dn58 bout", {7'd0, w_bout}, 8'h00);

    // T4: digit ripple and full sweep
    EN = 1'b0; LOAD = 1'b1; DIN = 8'h09;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    step();
    chk("rip up 10", w_dout, 8'h10);
    UP = 1'b0;
    step();
    chk("rip dn 09", w_dout, 8'h09);
    EN = 1'b0; LOAD = 1'b1; DIN = 8'h00;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      exp_v = 8'(((k % 60) / 10) * 16 + (k % 10));
      chk("sweep", w_dout, exp_v);
    end
    chk("sweep end cout", {7'd0, w_cout}, 8'h01);

    // T5: load reject and priority
    EN = 1'b0; LOAD = 1'b1; DIN = 8'h3A;
    step();
    chk("rej3A dout", w_dout, 8'h00);
    chk("rej3A err", {7'd0, w_err}, 8'h01);
    LOAD = 1'b0;
    step();
    chk("err drop", {7'd0, w_err}, 8'h00);
    LOAD = 1'b1; DIN = 8'h60;
    step();
    chk("rej60 err", {7'd0, w_err}, 8'h01);
    chk("rej60 dout", w_dout, 8'h00);
    EN = 1'b1; UP = 1'b1; DIN = 8'h25;
    step();
    chk("ld25 prio", w_dout, 8'h25);
    chk("ld25 err", {7'd0, w_err}, 8'h00);
    chk("sat ld25", s_dout, 8'h25);

    // T6: saturation, EN gating, reset mid-sweep
    DIN = 8'h59;
    step();
    LOAD = 1'b0;
    step();
    chk("sat hold59", s_dout, 8'h59);
    chk("sat cout", {7'd0, s_cout}, 8'h00);
    chk("wrap ref 00", w_dout, 8'h00);
    EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("en0 sat", s_dout, 8'h59);
      chk("en0 wrap", w_dout, 8'h00);
    end
    LOAD = 1'b1; DIN = 8'h00;
    step();
    LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
    step();
    chk("sat hold00", s_dout, 8'h00);
    chk("sat bout", {7'd0, s_bout}, 8'h00);
    chk("wrap bout", {7'd0, w_bout}, 8'h01);
    UP = 1'b1;
    step();
    step();
    chk("sweep pre rst", s_dout, 8'h02);
    RST = 1'b0;
    #2;
    chk("mid rst wrap", w_dout, 8'h00);
    chk("mid rst sat", s_dout, 8'h00);
    step();
    chk("held rst", s_dout, 8'h00);
    RST = 1'b1;
    EN = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
